// File: rtl/ar_channel_arbiter.sv
// Demand/prefetch arbiter for the shared downstream AXI read-address channel.
// Demand wins by default; prefetch is credit-limited and gets forced in after a run of demand wins.
module ar_channel_arbiter #(
    parameter int unsigned ADDR_BITS       = 16,
    parameter int unsigned BURST_LEN_WIDTH = 8,
    parameter int unsigned TID_WIDTH       = 8,
    parameter int unsigned STARVE_WIDTH    = 4,
    parameter int unsigned CREDIT_WIDTH    = 3
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       en,
    input  logic                       d_ar_valid,
    output logic                       d_ar_ready,
    input  logic [ADDR_BITS-1:0]       d_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] d_ar_len,
    input  logic [TID_WIDTH-1:0]       d_ar_id,
    input  logic                       p_ar_valid,
    output logic                       p_ar_ready,
    input  logic [ADDR_BITS-1:0]       p_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] p_ar_len,
    input  logic [TID_WIDTH-1:0]       p_ar_id,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [TID_WIDTH-1:0]       m_ar_id,
    output logic                       m_ar_src,
    input  logic                       pf_credit_return,
    input  logic [CREDIT_WIDTH-1:0]    crs_pfCredits,
    input  logic [STARVE_WIDTH-1:0]    crs_starveLimit,
    output logic [CREDIT_WIDTH-1:0]    pf_outstanding,
    output logic                       err
);

    typedef struct packed {
        logic [ADDR_BITS-1:0]       addr;
        logic [BURST_LEN_WIDTH-1:0] len;
        logic [TID_WIDTH-1:0]       id;
        logic                       src;
    } ar_t;

    logic [STARVE_WIDTH-1:0] starve_cnt;
    logic                    slot_free;
    logic                    can_grant;
    logic                    pf_elig;
    logic                    force_pf;
    logic                    grant_d;
    logic                    grant_p;
    ar_t                     out_q;
    ar_t                     win;

    // Arbitration; reset gating keeps both readies low while the block is held in reset.
    always_comb begin
        slot_free  = ~m_ar_valid | m_ar_ready;
        can_grant  = slot_free & en & resetN;
        pf_elig    = p_ar_valid & (pf_outstanding < crs_pfCredits);
        force_pf   = pf_elig & (crs_starveLimit != '0) & (starve_cnt >= crs_starveLimit);
        grant_p    = can_grant & (force_pf | (~d_ar_valid & pf_elig));
        grant_d    = can_grant & ~force_pf & d_ar_valid;
        d_ar_ready = grant_d;
        p_ar_ready = grant_p;
        win        = grant_p ? ar_t'{p_ar_addr, p_ar_len, p_ar_id, 1'b1}
                             : ar_t'{d_ar_addr, d_ar_len, d_ar_id, 1'b0};
    end

    // Output register: payload only moves when a new grant loads it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_ar_valid <= 1'b0;
            out_q      <= '0;
        end else if (grant_d | grant_p) begin
            m_ar_valid <= 1'b1;
            out_q      <= win;
        end else if (m_ar_ready) begin
            m_ar_valid <= 1'b0;
        end
    end

    assign m_ar_addr = out_q.addr;
    assign m_ar_len  = out_q.len;
    assign m_ar_id   = out_q.id;
    assign m_ar_src  = out_q.src;

    // Consecutive demand wins while prefetch was waiting; frozen while disabled.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            starve_cnt <= '0;
        end else if (en) begin
            if (grant_p || !pf_elig) begin
                starve_cnt <= '0;
            end else if (grant_d && starve_cnt != '1) begin
                starve_cnt <= starve_cnt + STARVE_WIDTH'(1);
            end
        end
    end

    // Outstanding prefetch bursts; an unmatched return at zero is flagged, not wrapped.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pf_outstanding <= '0;
            err            <= 1'b0;
        end else begin
            case ({grant_p, pf_credit_return})
                2'b10: pf_outstanding <= pf_outstanding + CREDIT_WIDTH'(1);
                2'b01: begin
                    if (pf_outstanding == '0) begin
                        err <= 1'b1;
                    end else begin
                        pf_outstanding <= pf_outstanding - CREDIT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ar_channel_arbiter.sv
// Directed bench for ar_channel_arbiter: expected ARs are queued at grant time and
// compared when the downstream handshake is seen.
module tb_ar_channel_arbiter;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic        src;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic        en;
    logic        d_ar_valid, d_ar_ready;
    logic [15:0] d_ar_addr;
    logic [7:0]  d_ar_len, d_ar_id;
    logic        p_ar_valid, p_ar_ready;
    logic [15:0] p_ar_addr;
    logic [7:0]  p_ar_len, p_ar_id;
    logic        m_ar_valid, m_ar_ready;
    logic [15:0] m_ar_addr;
    logic [7:0]  m_ar_len, m_ar_id;
    logic        m_ar_src;
    logic        pf_credit_return;
    logic [2:0]  crs_pfCredits;
    logic [3:0]  crs_starveLimit;
    logic [2:0]  pf_outstanding;
    logic        err;

    int   vectors = 0;
    int   errors  = 0;
    int   seq     = 0;
    bit   fix_d   = 1'b0;
    exp_t sb[$];

    localparam int NONE = 0;
    localparam int DEM  = 1;
    localparam int PF   = 2;

    ar_channel_arbiter dut (
        .clk(clk), .resetN(resetN), .en(en),
        .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready),
        .d_ar_addr(d_ar_addr), .d_ar_len(d_ar_len), .d_ar_id(d_ar_id),
        .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready),
        .p_ar_addr(p_ar_addr), .p_ar_len(p_ar_len), .p_ar_id(p_ar_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_ar_src(m_ar_src), .pf_credit_return(pf_credit_return),
        .crs_pfCredits(crs_pfCredits), .crs_starveLimit(crs_starveLimit),
        .pf_outstanding(pf_outstanding), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; exp_g names the requester that must win this cycle.
    task automatic cyc(input bit dv, input bit pv, input bit mr, input bit ret, input int exp_g);
        seq++;
        d_ar_valid       = dv;
        p_ar_valid       = pv;
        m_ar_ready       = mr;
        pf_credit_return = ret;
        d_ar_addr        = fix_d ? 16'h0eef : 16'h1000 + 16'(seq);
        d_ar_len         = fix_d ? 8'd0 : 8'(seq);
        d_ar_id          = fix_d ? 8'd5 : 8'(seq);
        p_ar_addr        = 16'h8000 + 16'(seq);
        p_ar_len         = 8'(seq + 1);
        p_ar_id          = 8'(seq + 100);
        #1;
        chk("d_ar_ready", d_ar_ready, exp_g == DEM);
        chk("p_ar_ready", p_ar_ready, exp_g == PF);
        if (exp_g == DEM) sb.push_back(exp_t'{d_ar_addr, d_ar_len, d_ar_id, 1'b0});
        if (exp_g == PF)  sb.push_back(exp_t'{p_ar_addr, p_ar_len, p_ar_id, 1'b1});
        @(posedge clk);
        #1;
        pf_credit_return = 1'b0;
    endtask

    // Downstream monitor: every completed AR must match the oldest expected grant.
    always @(negedge clk) begin
        if (resetN && m_ar_valid && m_ar_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ar", 40'(m_ar_valid), 40'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ar_payload", 40'({m_ar_addr, m_ar_len, m_ar_id, m_ar_src}), 40'(e));
            end
        end
    end

    initial begin
        resetN = 1'b0; en = 1'b1;
        d_ar_valid = 1'b0; p_ar_valid = 1'b0; m_ar_ready = 1'b0; pf_credit_return = 1'b0;
        d_ar_addr = '0; d_ar_len = '0; d_ar_id = '0;
        p_ar_addr = '0; p_ar_len = '0; p_ar_id = '0;
        crs_pfCredits = 3'd4; crs_starveLimit = 4'd0;
        #3;
        chk("rst_m_valid", m_ar_valid, 1'b0);
        chk("rst_payload", 40'({m_ar_addr, m_ar_len, m_ar_id, m_ar_src}), 40'd0);
        chk("rst_pf_out", pf_outstanding, 3'd0);
        chk("rst_err", err, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        resetN = 1'b1;

        // Strict demand priority
        for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, DEM);
        cyc(0, 0, 1, 0, NONE);
        chk("dprio_drained", m_ar_valid, 1'b0);
        chk("dprio_pf_out", pf_outstanding, 3'd0);

        // Starvation forcing: D,D,D,P,D,D,D,P
        crs_starveLimit = 4'd3;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, DEM);
            cyc(1, 1, 1, 0, PF);
        end
        cyc(0, 0, 1, 0, NONE);
        chk("starve_pf_out", pf_outstanding, 3'd2);
        cyc(0, 0, 1, 1, NONE);
        cyc(0, 0, 1, 1, NONE);
        chk("starve_returned", pf_outstanding, 3'd0);

        // Credit limit, and a return re-opens exactly one grant a cycle later
        crs_starveLimit = 4'd0;
        crs_pfCredits   = 3'd2;
        cyc(0, 1, 1, 0, PF);
        cyc(0, 1, 1, 0, PF);
        cyc(0, 1, 1, 0, NONE);
        chk("credit_full", pf_outstanding, 3'd2);
        cyc(0, 1, 1, 1, NONE);
        chk("credit_after_ret", pf_outstanding, 3'd1);
        cyc(0, 1, 1, 0, PF);
        cyc(0, 1, 1, 0, NONE);
        chk("credit_refull", pf_outstanding, 3'd2);

        // Underflow error, then simultaneous grant and return
        cyc(0, 0, 1, 1, NONE);
        cyc(0, 0, 1, 1, NONE);
        chk("err_before", err, 1'b0);
        cyc(0, 0, 1, 1, NONE);
        chk("err_set", err, 1'b1);
        chk("err_count_zero", pf_outstanding, 3'd0);
        cyc(0, 1, 1, 0, PF);
        cyc(0, 1, 1, 1, PF);
        chk("simul_count", pf_outstanding, 3'd1);
        cyc(0, 0, 1, 0, NONE);

        // Backpressure holds the loaded payload stable
        fix_d = 1'b1;
        cyc(1, 0, 1, 0, DEM);
        fix_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0, NONE);
            chk("bp_valid", m_ar_valid, 1'b1);
            chk("bp_payload", 40'({m_ar_addr, m_ar_len, m_ar_id, m_ar_src}),
                40'({16'h0eef, 8'd0, 8'd5, 1'b0}));
        end
        cyc(1, 1, 1, 0, DEM);
        cyc(0, 0, 1, 0, NONE);
        chk("bp_drained", m_ar_valid, 1'b0);

        // Disabled: no grants, pending output still completes
        cyc(1, 0, 0, 0, DEM);
        en = 1'b0;
        cyc(1, 1, 0, 0, NONE);
        cyc(1, 1, 0, 0, NONE);
        cyc(1, 1, 1, 0, NONE);
        chk("en0_completed", m_ar_valid, 1'b0);
        chk("en0_sb_empty", 40'(sb.size()), 40'd0);
        en = 1'b1;

        // Reset mid-backpressure
        cyc(1, 0, 0, 0, DEM);
        cyc(1, 0, 0, 0, NONE);
        chk("pre_rst_valid", m_ar_valid, 1'b1);
        chk("pre_rst_pf_out", pf_outstanding, 3'd1);
        #2;
        resetN = 1'b0;
        #1;
        chk("rst2_m_valid", m_ar_valid, 1'b0);
        chk("rst2_pf_out", pf_outstanding, 3'd0);
        chk("rst2_err", err, 1'b0);
        chk("rst2_readies", {d_ar_ready, p_ar_ready}, 2'b00);
        sb.delete();
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cyc(0, 1, 1, 0, PF);
        cyc(0, 0, 1, 0, NONE);
        chk("post_rst_pf_out", pf_outstanding, 3'd1);
        chk("final_sb_empty", 40'(sb.size()), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
